// File: rtl/hex_entry_pkg.sv
// hex_entry shared constants: digit count and timing for 50 MHz and sim.
// Also shared with the display top-level and the testbench.
package hex_entry_pkg;

    localparam int HEX_DIGITS          = 6;
    localparam int DEBOUNCE_CYCLES_50M = 1000000;
    localparam int BLINK_CYCLES_50M    = 12500000;
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_BLINK_CYCLES    = 8;

    typedef struct packed {
        logic clr;
        logic inc;
        logic sel;
    } key_press_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_entry_if.sv
// hex_entry key/display bundle: raw active-low keys in,
// edited value, cursor and blink enable out.
interface hex_entry_if
    import hex_entry_pkg::*;
#(
    parameter int DIGITS = HEX_DIGITS
);

    logic                  KEY_SEL_N;
    logic                  KEY_INC_N;
    logic                  KEY_CLR_N;
    logic [4*DIGITS-1:0]   value;
    logic [2:0]            cursor;
    logic                  blink;
    logic                  changed;

    modport master (
        output KEY_SEL_N,
        output KEY_INC_N,
        output KEY_CLR_N,
        input  value,
        input  cursor,
        input  blink,
        input  changed
    );

    modport slave (
        input  KEY_SEL_N,
        input  KEY_INC_N,
        input  KEY_CLR_N,
        output value,
        output cursor,
        output blink,
        output changed
    );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: two-flop sync, stable-count debouncer and press pulse
// for one raw active-low pushbutton.
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [1:0]    warm;
    logic          armed;
    logic          settle;

    assign settle = (s2 != level) && (cnt == LAST);

    // A key held through reset must be seen released before it can fire.
    assign press = settle && level && armed;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1   <= key_n;
            s2   <= s1;
            warm <= {warm[0], 1'b1};
            if (warm[1] && s2 && level)
                armed <= 1'b1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_entry.sv
// hex_entry: three debounced keys edit a DIGITS-wide hex value
// under a digit cursor; also drives the cursor blink enable.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DIGITS          = HEX_DIGITS,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int BLINK_CYCLES    = BLINK_CYCLES_50M
) (
    input  logic     CLOCK_50,
    input  logic     RESET_N,
    hex_entry_if.slave bus
);

    localparam int W  = 4 * DIGITS;
    localparam int BW = cnt_width(BLINK_CYCLES);
    localparam logic [2:0]    LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [BW-1:0] BLAST      = BW'(BLINK_CYCLES - 1);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("hex_entry: DIGITS must be in 1..8");
        end
    endgenerate

    key_press_t    p;
    logic [2:0]    lvl;
    logic          unused_lvl;
    logic [W-1:0]  value_q;
    logic [2:0]    cursor_q;
    logic          changed_q;
    logic [BW-1:0] bcnt;
    logic          blink_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (bus.KEY_SEL_N),
        .level    (lvl[0]),
        .press    (p.sel)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (bus.KEY_INC_N),
        .level    (lvl[1]),
        .press    (p.inc)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (bus.KEY_CLR_N),
        .level    (lvl[2]),
        .press    (p.clr)
    );

    assign unused_lvl = ^lvl;

    // Increment uses the pre-update cursor when sel fires together.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            value_q   <= '0;
            cursor_q  <= '0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= p.clr | p.inc;
            if (p.clr) begin
                value_q  <= '0;
                cursor_q <= '0;
            end else begin
                if (p.inc) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cursor_q == 3'(i))
                            value_q[4*i +: 4] <= value_q[4*i +: 4] + 4'd1;
                    end
                end
                if (p.sel)
                    cursor_q <= (cursor_q == LAST_DIGIT) ? 3'd0
                                                         : cursor_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            bcnt    <= '0;
            blink_q <= 1'b0;
        end else if (bcnt == BLAST) begin
            bcnt    <= '0;
            blink_q <= ~blink_q;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign bus.value   = value_q;
    assign bus.cursor  = cursor_q;
    assign bus.blink   = blink_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: directed key sequences against hex_entry with
// reduced debounce/blink periods and hand-computed expectations.
module tb_hex_entry;
    import hex_entry_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   chg_cnt;

    hex_entry_if #(.DIGITS(HEX_DIGITS)) bus ();

    hex_entry #(
        .DIGITS          (HEX_DIGITS),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .BLINK_CYCLES    (SIM_BLINK_CYCLES)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.changed === 1'b1)
            chg_cnt = chg_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // m = {clr, inc, sel}, 1 = pressed
    task automatic set_keys(input logic [2:0] m);
        bus.KEY_CLR_N = ~m[2];
        bus.KEY_INC_N = ~m[1];
        bus.KEY_SEL_N = ~m[0];
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        @(negedge clk);
        set_keys(m);
        repeat (hold) @(negedge clk);
        set_keys(3'b000);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chg_cnt  = 0;
        rst_n    = 1'b0;
        set_keys(3'b000);
        #1;
        chk("rst_value", 32'(bus.value), 32'h0);
        chk("rst_cursor", 32'(bus.cursor), 32'h0);
        chk("rst_blink", 32'(bus.blink), 32'h0);
        chk("rst_changed", 32'(bus.changed), 32'h0);
        do_reset();
        repeat (4) @(negedge clk);

        // 1: latency 2 sync + 4 debounce, no auto-repeat
        chg_cnt = 0;
        set_keys(3'b010);
        repeat (5) @(posedge clk);
        #1 chk("lat_before", 32'(bus.value), 32'h0);
        @(posedge clk);
        #1 chk("lat_value", 32'(bus.value), 32'h000001);
        chk("lat_changed", 32'(bus.changed), 32'h1);
        @(posedge clk);
        #1 chk("lat_chg_off", 32'(bus.changed), 32'h0);
        repeat (4) @(negedge clk);
        set_keys(3'b000);
        repeat (8) @(negedge clk);
        chk("hold_value", 32'(bus.value), 32'h000001);
        chk("hold_chg", 32'(chg_cnt), 32'd1);
        for (int i = 0; i < 3; i++) press(3'b010, 10);
        chk("inc4_value", 32'(bus.value), 32'h000004);
        chk("inc4_chg", 32'(chg_cnt), 32'd4);

        // 2: bounce shorter than debounce is rejected
        chg_cnt = 0;
        @(negedge clk);
        set_keys(3'b010);
        repeat (3) @(negedge clk);
        set_keys(3'b000);
        @(negedge clk);
        set_keys(3'b010);
        repeat (3) @(negedge clk);
        set_keys(3'b000);
        repeat (10) @(negedge clk);
        chk("bounce_value", 32'(bus.value), 32'h000004);
        chk("bounce_chg", 32'(chg_cnt), 32'd0);

        // 3: clear, cursor walk, digit 5 wraps without carry
        press(3'b100, 10);
        chk("clr_value", 32'(bus.value), 32'h0);
        chk("clr_chg", 32'(chg_cnt), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            press(3'b001, 10);
            chk("sel_cursor", 32'(bus.cursor), 32'(i));
        end
        chg_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            press(3'b010, 10);
            if (i == 10) chk("d5_A", 32'(bus.value), 32'hA00000);
            if (i == 15) chk("d5_F", 32'(bus.value), 32'hF00000);
        end
        chk("d5_wrap", 32'(bus.value), 32'h000000);
        chk("d5_chg", 32'(chg_cnt), 32'd16);
        press(3'b001, 10);
        chk("sel_wrap", 32'(bus.cursor), 32'h0);

        // 4: sel+inc together, then all three
        press(3'b001, 10);
        press(3'b001, 10);
        chk("cur2", 32'(bus.cursor), 32'd2);
        press(3'b011, 10);
        chk("si_value", 32'(bus.value), 32'h000100);
        chk("si_cursor", 32'(bus.cursor), 32'd3);
        chg_cnt = 0;
        press(3'b111, 10);
        chk("all_value", 32'(bus.value), 32'h0);
        chk("all_cursor", 32'(bus.cursor), 32'h0);
        chk("all_chg", 32'(chg_cnt), 32'd1);

        // 5: reset mid-debounce, held key ignored after release
        press(3'b001, 10);
        for (int i = 0; i < 10; i++) press(3'b010, 10);
        chk("pre_value", 32'(bus.value), 32'h0000A0);
        chk("pre_cursor", 32'(bus.cursor), 32'd1);
        @(negedge clk);
        set_keys(3'b010);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_value", 32'(bus.value), 32'h0);
        chk("mid_cursor", 32'(bus.cursor), 32'h0);
        chk("mid_blink", 32'(bus.blink), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chg_cnt = 0;
        repeat (20) @(negedge clk);
        chk("held_value", 32'(bus.value), 32'h0);
        chk("held_chg", 32'(chg_cnt), 32'd0);
        set_keys(3'b000);
        repeat (10) @(negedge clk);
        press(3'b010, 10);
        chk("repress_value", 32'(bus.value), 32'h000001);

        // 6: blink high during cycles 8-15 and 24-31 after reset
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1 chk("blink", 32'(bus.blink), 32'((k / 8) & 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_entry.md
Name: hex_entry

Overview:
- Input-side counterpart of the six-digit seven-segment output path: turns raw board pushbuttons into a 24-bit hex value that the display chain then shows.
- Debounces three active-low keys and detects presses.
- Maintains a digit cursor and edits the selected nibble.
- Exports the value, the cursor and a cursor blink enable for the display mux.

Parameters:
- DIGITS, 6: number of hex digits edited; value width = 4*DIGITS.
- DEBOUNCE_CYCLES, 1000000: clocks a key must be stable before a level change is accepted (20 ms at 50 MHz).
- BLINK_CYCLES, 12500000: clocks per blink half-period (4 Hz toggle at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY_SEL_N  input  1  raw pushbutton, active low, asynchronous to CLOCK_50; press advances the cursor.
- KEY_INC_N  input  1  raw pushbutton, active low, asynchronous; press increments the digit under the cursor.
- KEY_CLR_N  input  1  raw pushbutton, active low, asynchronous; press clears the value and the cursor.
- value  output  4*DIGITS  edited value; digit i = value[4i+3:4i]; digit 0 is rightmost.
- cursor  output  3  index of the selected digit, 0..DIGITS-1.
- blink  output  1  toggles every BLINK_CYCLES; the display blanks the cursor digit while high.
- changed  output  1  one-cycle pulse the cycle after value is written.

Behaviour:
Reset and clocking:
- Single clock domain CLOCK_50.
- RESET_N low asynchronously forces:
  - value=0, cursor=0, blink=0, changed=0;
  - all synchronizer flops to 1 (released);
  - debounce counters to 0;
  - debounced levels to 1 (released).
- Reset asserted mid-debounce or mid-press discards that press. No event is generated on reset release, even if a key is held; a held key must first be released and pressed again.

Per-key input path:
- Two-flop synchronizer, reset value 1.
- Debouncer with its own counter:
  - when the synced level equals the debounced level, the counter clears;
  - otherwise the counter increments;
  - when the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count and is rejected.
- Press event: a one-cycle pulse when the debounced level goes 1->0. Release produces no event.
- Latency: pin falling edge -> press pulse = 2 sync cycles + DEBOUNCE_CYCLES cycles. With all three keys identical, the pulses align.

Edit logic (evaluated each cycle on the press pulses clr_p, inc_p, sel_p):
- clr_p: value <= 0, cursor <= 0. Overrides inc_p and sel_p in the same cycle.
- inc_p (no clr_p): the digit at cursor becomes (digit+1) mod 16. F wraps to 0 with no carry into the neighbouring digit. Other digits are unchanged.
- sel_p (no clr_p): cursor <= cursor+1, wrapping from DIGITS-1 to 0.
- inc_p and sel_p in the same cycle: the increment uses the pre-update cursor, and the cursor advances in the same cycle.
- changed = registered (clr_p | inc_p), so it is high exactly one cycle after the value update. A clear of an already-zero value still pulses changed.

Blink:
- Free-running counter 0..BLINK_CYCLES-1.
- blink toggles when the counter wraps.
- The counter is independent of the keys and is reset only by RESET_N.

Width rules:
- Counter widths are $clog2 of the parameter, minimum 1.
- The cursor is 3 bits; DIGITS must be in 1..8, and a parameter check flags DIGITS>8.

Decomposition:
- Shared constants header: default DEBOUNCE_CYCLES and BLINK_CYCLES for 50 MHz, the simulation-reduced values, and DIGITS=6. These are shared with the display top-level and testbench.
- One sub-module, key_debounce (parameter DEBOUNCE_CYCLES), instantiated once per key:
  - ports: CLOCK_50, RESET_N, key_n, level, press.
  - contents: synchronizer, counter, debounced level, falling-edge pulse.
- The hex_entry top holds the edit registers, cursor, blink counter and changed flag.

Test Plan (sim with DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
1. Reset, then KEY_INC_N low for 10 cycles.
   -> After 6 cycles (2 sync + 4 debounce), value goes 000000 -> 000001; changed pulses once; holding the key does not repeat. Three more press/release cycles -> 000004.
2. Bounce: KEY_INC_N low 3 cycles, high 1, low 3, high.
   -> No press; value unchanged; changed stays 0.
3. Cursor wrap: six SEL presses.
   -> cursor 1,2,3,4,5,0.
   At cursor 5, 16 INC presses -> digit 5 goes 0..F..0; value returns to 000000 with no carry; changed pulses 16 times.
4. SEL and INC asserted on the same cycle at cursor 2.
   -> value 000100; cursor 3.
   Next, all three keys together -> value 000000, cursor 0, changed pulses once.
5. RESET_N asserted 3 cycles into an INC debounce with value 0000A0 and cursor 1.
   -> Immediately value 000000, cursor 0, blink 0.
   Key still held at release -> no increment until it is released and pressed again.
6. Idle 40 cycles after reset.
   -> blink toggles at cycles 8, 16, 24, 32 (high during cycles 8-15 and 24-31).
